tag_ram_lookup_ctrl: RTL and testbench
======================================

// Module: tag_ram_lookup_ctrl
// PURPOSE
//  Requester side of the synchronous-read tag RAM: drives addr/din/we and samples dout one cycle later.
//  Serves tag lookup requests: splits the address into index and tag, reads the entry, compares it and
//  reports hit or miss. On an allocating miss it writes the new tag into the entry. Also invalidates the
//  whole RAM after reset and on a flush request. Sits between the cache pipeline and one tag RAM instance.
// PARAMETERS
//  AWIDTH   3    tag RAM address width (index bits); DEPTH = 1<<AWIDTH
//  DWIDTH   9    tag RAM word width: bit [DWIDTH-1] = valid, bits [DWIDTH-2:0] = tag (TAG_W = DWIDTH-1)
//  CNT_W    16   width of the hit and miss statistics counters
// PORTS
//  clock        in   1             single clock, all state on posedge
//  reset        in   1             synchronous, active-high
//  req_valid    in   1             lookup request valid
//  req_ready    out  1             controller can accept a request
//  req_addr     in   TAG_W+AWIDTH  {tag, index}; index = [AWIDTH-1:0]
//  req_alloc    in   1             write the tag into the entry on a miss
//  resp_valid   out  1             one-cycle response pulse
//  resp_hit     out  1             1 = stored entry is valid and its tag equals the request tag
//  resp_victim  out  DWIDTH        raw entry read on lookup (valid+tag), used for eviction
//  flush        in   1             pulse: invalidate all entries
//  busy         out  1             high when state != IDLE
//  hit_count    out  CNT_W         saturating count of hits
//  miss_count   out  CNT_W         saturating count of misses
//  ram_addr     out  AWIDTH        to tag RAM addr
//  ram_din      out  DWIDTH        to tag RAM din
//  ram_we       out  1             to tag RAM we
//  ram_dout     in   DWIDTH        from tag RAM dout; valid one cycle after ram_addr is sampled
// BEHAVIOUR
//  - Reset (sync, active-high): state=INIT, sweep_cnt=0, flush_pend=0, resp_valid=0, resp_hit=0,
//    resp_victim=0, hit_count=0, miss_count=0. ram_we is forced to 0 while reset is high.
//    A reset asserted mid-operation aborts the operation. Any accepted request gets no response.
//  - INIT/FLUSH sweep: ram_we=1, ram_addr=sweep_cnt, ram_din=0. Runs DEPTH cycles, then enters IDLE.
//    req_ready=0 throughout.
//  - IDLE: req_ready = !flush_pend. If flush_pend is set, clear it and enter INIT with sweep_cnt=0.
//    Otherwise, on req_valid&&req_ready, latch {tag,index,alloc} and enter LOOKUP.
//  - flush is sampled in every state and sets flush_pend. It is served only from IDLE, so it never
//    interrupts a lookup. If flush and a request handshake occur in the same cycle, the request is
//    completed first. A flush during a sweep is merged into that sweep.
//  - LOOKUP: ram_addr=index, ram_we=0. Next state is COMPARE.
//  - COMPARE: ram_dout is valid. hit = ram_dout[DWIDTH-1] && (ram_dout[DWIDTH-2:0]==tag).
//    On a miss with alloc=1: ram_we=1, ram_addr=index, ram_din={1'b1,tag}, written at this edge.
//    Register resp_hit and resp_victim=ram_dout. Increment hit_count or miss_count, saturating at
//    all-ones. Next state is RESP.
//  - RESP: resp_valid=1 for exactly one cycle; resp_hit/resp_victim hold until the next COMPARE.
//    Next state is IDLE.
//  - Latency: handshake at edge k gives resp_valid high between edges k+2 and k+3.
//    Max throughput is 1 request per 4 cycles.
//  - A miss with alloc=0 leaves the RAM untouched. A hit never writes.
//  - Lookup immediately after an allocating miss to the same address must hit. The write lands
//    before the next LOOKUP read.
//  - ram_addr/ram_din are 0 in IDLE and RESP. ram_we is 1 only in INIT and allocating-miss COMPARE.
// STRUCTURE
//  - Shared package: state encoding (INIT, IDLE, LOOKUP, COMPARE, RESP), TAG_W=DWIDTH-1,
//    VALID_BIT=DWIDTH-1 constants.
//  - One sub-module, sat_counter (CNT_W wide, inc, reset), instantiated twice for hit/miss counts.
//  - Top-level test harness connects this block to one tag RAM instance (AWIDTH=3, DWIDTH=9).
// TESTING
//  - Reset then 8 cycles -> ram_we=1 with addr 0..7 and din=0; req_ready rises on cycle 9, busy=0.
//  - Lookup addr=6'b101_011, alloc=1 after init -> resp_hit=0, resp_victim=0, miss_count=1.
//    Entry 3 now reads 9'b1_0000_0101.
//  - Repeat the same lookup -> resp_hit=1, resp_victim=9'h105, hit_count=1.
//    resp_valid comes 2 cycles after the handshake.
//  - Lookup addr=6'b110_011, alloc=0 -> resp_hit=0, victim=9'h105; entry 3 unchanged, re-lookup of tag 5 hits.
//  - flush with a same-cycle request handshake -> the response arrives first, then an 8-cycle sweep.
//    A later lookup of tag 5 misses.
//  - Assert reset during COMPARE of an allocating miss -> no RAM write, no resp_valid.
//    Counters are 0 and the sweep restarts. Preload miss_count=16'hFFFF -> a further miss holds it at FFFF.

Source files
------------

// File: rtl/tag_ram_lookup_pkg.sv
// rtl/tag_ram_lookup_pkg.sv - shared constants and state encoding for the tag RAM lookup controller
package tag_ram_lookup_pkg;

  localparam int DEF_AWIDTH = 3;
  localparam int DEF_DWIDTH = 9;
  localparam int DEF_CNT_W  = 16;
  localparam int TAG_W      = DEF_DWIDTH - 1;
  localparam int VALID_BIT  = DEF_DWIDTH - 1;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LOOKUP  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/tag_ram_lookup_ctrl_sat_counter.sv
// rtl/tag_ram_lookup_ctrl_sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tag_ram_lookup_ctrl.sv
// rtl/tag_ram_lookup_ctrl.sv - tag RAM requester: lookup/compare/allocate plus invalidate sweep
module tag_ram_lookup_ctrl
  import tag_ram_lookup_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DWIDTH-1+AWIDTH-1:0] req_addr,
  input  logic                       req_alloc,
  output logic                       resp_valid,
  output logic                       resp_hit,
  output logic [DWIDTH-1:0]          resp_victim,
  input  logic                       flush,
  output logic                       busy,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           miss_count,
  output logic [AWIDTH-1:0]          ram_addr,
  output logic [DWIDTH-1:0]          ram_din,
  output logic                       ram_we,
  input  logic [DWIDTH-1:0]          ram_dout
);

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic                flush_pend_q, flush_pend_d;
  logic [DWIDTH-2:0]   tag_q, tag_d;
  logic [AWIDTH-1:0]   index_q, index_d;
  logic                alloc_q, alloc_d;
  logic                resp_hit_q, resp_hit_d;
  logic [DWIDTH-1:0]   resp_victim_q, resp_victim_d;
  logic                hit;

  assign hit = ram_dout[DWIDTH-1] && (ram_dout[DWIDTH-2:0] == tag_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_INIT;
      sweep_cnt_q   <= '0;
      flush_pend_q  <= 1'b0;
      tag_q         <= '0;
      index_q       <= '0;
      alloc_q       <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_victim_q <= '0;
    end else begin
      state_q       <= state_d;
      sweep_cnt_q   <= sweep_cnt_d;
      flush_pend_q  <= flush_pend_d;
      tag_q         <= tag_d;
      index_q       <= index_d;
      alloc_q       <= alloc_d;
      resp_hit_q    <= resp_hit_d;
      resp_victim_q <= resp_victim_d;
    end
  end

  // A flush arriving mid-sweep is absorbed by that sweep; otherwise it waits for IDLE.
  always_comb begin
    state_d       = state_q;
    sweep_cnt_d   = sweep_cnt_q;
    flush_pend_d  = flush_pend_q | flush;
    tag_d         = tag_q;
    index_d       = index_q;
    alloc_d       = alloc_q;
    resp_hit_d    = resp_hit_q;
    resp_victim_d = resp_victim_q;
    case (state_q)
      ST_INIT: begin
        flush_pend_d = flush_pend_q;
        sweep_cnt_d  = sweep_cnt_q + AWIDTH'(1);
        if (sweep_cnt_q == {AWIDTH{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (flush_pend_q) begin
          flush_pend_d = 1'b0;
          sweep_cnt_d  = '0;
          state_d      = ST_INIT;
        end else if (req_valid) begin
          tag_d   = req_addr[DWIDTH-1+AWIDTH-1:AWIDTH];
          index_d = req_addr[AWIDTH-1:0];
          alloc_d = req_alloc;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = ST_COMPARE;
      ST_COMPARE: begin
        resp_hit_d    = hit;
        resp_victim_d = ram_dout;
        state_d       = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE) && !flush_pend_q;
    busy       = (state_q != ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    ram_addr   = '0;
    ram_din    = '0;
    ram_we     = 1'b0;
    case (state_q)
      ST_INIT: begin
        ram_addr = sweep_cnt_q;
        ram_we   = 1'b1;
      end
      ST_LOOKUP: ram_addr = index_q;
      ST_COMPARE: begin
        ram_addr = index_q;
        if (!hit && alloc_q) begin
          ram_we  = 1'b1;
          ram_din = {1'b1, tag_q};
        end
      end
      default: ;
    endcase
    // Reset must never let a half-finished write reach the RAM.
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  assign resp_hit    = resp_hit_q;
  assign resp_victim = resp_victim_q;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clock (clock),
    .reset (reset),
    .inc   ((state_q == ST_COMPARE) && hit),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clock (clock),
    .reset (reset),
    .inc   ((state_q == ST_COMPARE) && !hit),
    .count (miss_count)
  );

endmodule

// File: tb/tb_tag_ram_lookup_ctrl.sv
// tb/tb_tag_ram_lookup_ctrl.sv - directed bench for tag_ram_lookup_ctrl with a behavioural tag RAM
module tb_tag_ram_lookup_ctrl;
  import tag_ram_lookup_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   req_valid;
  logic                   req_ready;
  logic [TAG_W+2:0]       req_addr;
  logic                   req_alloc;
  logic                   resp_valid;
  logic                   resp_hit;
  logic [8:0]             resp_victim;
  logic                   flush;
  logic                   busy;
  logic [15:0]            hit_count;
  logic [15:0]            miss_count;
  logic [2:0]             ram_addr;
  logic [8:0]             ram_din;
  logic                   ram_we;
  logic [8:0]             ram_dout;
  logic [8:0]             mem [0:7];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  tag_ram_lookup_ctrl #(.AWIDTH(3), .DWIDTH(9), .CNT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_alloc   (req_alloc),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_victim (resp_victim),
    .flush       (flush),
    .busy        (busy),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_dout    (ram_dout)
  );

  task automatic do_lookup(input logic [10:0] addr, input logic alloc, input logic with_flush,
                           output int lat, output logic hit, output logic [8:0] victim);
    int w;
    lat = 0; hit = 1'bx; victim = 'x;
    @(negedge clock);
    req_valid = 1'b1; req_addr = addr; req_alloc = alloc; flush = with_flush;
    #1;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clock); #1; w++; end
    if (!req_ready) begin
      n_cmp++; n_err++;
      $display("FAIL handshake_timeout req_ready=%0b required=1", req_ready);
      req_valid = 1'b0; flush = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (resp_valid) begin lat = n; hit = resp_hit; victim = resp_victim; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_alloc = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%0b exp=0", ram_we); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%0b exp=0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_victim !== 9'h0) begin
      n_err++; $display("FAIL reset_resp got=%0b/%0b/%h exp=0/0/000", resp_valid, resp_hit, resp_victim); end
    n_cmp++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
      n_err++; $display("FAIL reset_counts got=%h/%h exp=0000/0000", hit_count, miss_count); end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 3'(i) || ram_din !== 9'h0 || req_ready !== 1'b0) begin
        n_err++; $display("FAIL init_sweep_%0d got we=%0b addr=%0d din=%h rdy=%0b exp we=1 addr=%0d din=000 rdy=0",
                          i, ram_we, ram_addr, ram_din, req_ready, i); end
      @(negedge clock);
    end
    #1;
    n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL init_done got rdy=%0b busy=%0b exp rdy=1 busy=0", req_ready, busy); end
  endtask

  task automatic test_alloc_miss;
    int lat; logic hit; logic [8:0] victim;
    do_lookup({8'd5, 3'd3}, 1'b1, 1'b0, lat, hit, victim);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL alloc_miss_latency got=%0d exp=2", lat); end
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL alloc_miss_hit got=%0b exp=0", hit); end
    n_cmp++; if (victim !== 9'h000) begin n_err++; $display("FAIL alloc_miss_victim got=%h exp=000", victim); end
    n_cmp++; if (miss_count !== 16'd1) begin n_err++; $display("FAIL alloc_miss_count got=%0d exp=1", miss_count); end
    n_cmp++; if (mem[3] !== 9'h105) begin n_err++; $display("FAIL alloc_miss_entry got=%h exp=105", mem[3]); end
  endtask

  task automatic test_hit;
    int lat; logic hit; logic [8:0] victim;
    do_lookup({8'd5, 3'd3}, 1'b1, 1'b0, lat, hit, victim);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    n_cmp++; if (hit !== 1'b1 || victim !== 9'h105) begin
      n_err++; $display("FAIL hit_resp got=%0b/%h exp=1/105", hit, victim); end
    n_cmp++; if (hit_count !== 16'd1 || miss_count !== 16'd1) begin
      n_err++; $display("FAIL hit_counts got=%0d/%0d exp=1/1", hit_count, miss_count); end
    @(negedge clock);
    n_cmp++; if (resp_valid !== 1'b0 || resp_hit !== 1'b1) begin
      n_err++; $display("FAIL hit_pulse_hold got=%0b/%0b exp=0/1", resp_valid, resp_hit); end
  endtask

  task automatic test_noalloc_miss;
    int lat; logic hit; logic [8:0] victim;
    do_lookup({8'd6, 3'd3}, 1'b0, 1'b0, lat, hit, victim);
    n_cmp++; if (hit !== 1'b0 || victim !== 9'h105) begin
      n_err++; $display("FAIL noalloc_resp got=%0b/%h exp=0/105", hit, victim); end
    n_cmp++; if (mem[3] !== 9'h105 || miss_count !== 16'd2) begin
      n_err++; $display("FAIL noalloc_entry got=%h/%0d exp=105/2", mem[3], miss_count); end
    do_lookup({8'd5, 3'd3}, 1'b0, 1'b0, lat, hit, victim);
    n_cmp++; if (hit !== 1'b1 || hit_count !== 16'd2) begin
      n_err++; $display("FAIL noalloc_relookup got=%0b/%0d exp=1/2", hit, hit_count); end
  endtask

  task automatic test_flush_with_request;
    int lat; logic hit; logic [8:0] victim;
    do_lookup({8'd5, 3'd3}, 1'b0, 1'b1, lat, hit, victim);
    n_cmp++; if (lat !== 2 || hit !== 1'b1) begin
      n_err++; $display("FAIL flush_req_first got lat=%0d hit=%0b exp lat=2 hit=1", lat, hit); end
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b0 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL flush_pending got rdy=%0b we=%0b exp 0/0", req_ready, ram_we); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 3'(i) || busy !== 1'b1) begin
        n_err++; $display("FAIL flush_sweep_%0d got we=%0b addr=%0d busy=%0b exp we=1 addr=%0d busy=1",
                          i, ram_we, ram_addr, busy, i); end
    end
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL flush_done got rdy=%0b exp=1", req_ready); end
    do_lookup({8'd5, 3'd3}, 1'b0, 1'b0, lat, hit, victim);
    n_cmp++; if (hit !== 1'b0 || victim !== 9'h000 || miss_count !== 16'd3) begin
      n_err++; $display("FAIL post_flush_lookup got=%0b/%h/%0d exp=0/000/3", hit, victim, miss_count); end
  endtask

  task automatic test_reset_mid_compare;
    int seen;
    @(negedge clock);
    req_valid = 1'b1; req_addr = {8'd2, 3'd1}; req_alloc = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL compare_alloc_we got=%0b exp=1", ram_we); end
    reset = 1'b1;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_gates_we got=%0b exp=0", ram_we); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++; if (mem[1] !== 9'h000) begin n_err++; $display("FAIL reset_no_write got=%h exp=000", mem[1]); end
    n_cmp++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
      n_err++; $display("FAIL reset_mid_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 3'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL reset_sweep_restart got we=%0b addr=%0d busy=%0b exp 1/0/1", ram_we, ram_addr, busy); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) seen++;
      @(negedge clock);
    end
    n_cmp++; if (seen !== 0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_no_resp got resp_cycles=%0d rdy=%0b exp 0/1", seen, req_ready); end
  endtask

  task automatic test_saturation;
    int lat; logic hit; logic [8:0] victim;
    @(negedge clock);
    force dut.u_miss_cnt.count_q = 16'hFFFE;
    @(negedge clock);
    release dut.u_miss_cnt.count_q;
    do_lookup({8'd7, 3'd4}, 1'b0, 1'b0, lat, hit, victim);
    n_cmp++; if (miss_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach got=%h exp=FFFF", miss_count); end
    do_lookup({8'd7, 3'd4}, 1'b0, 1'b0, lat, hit, victim);
    n_cmp++; if (miss_count !== 16'hFFFF || hit_count !== 16'h0) begin
      n_err++; $display("FAIL sat_hold got=%h/%h exp=FFFF/0000", miss_count, hit_count); end
  endtask

  initial begin
    test_reset;
    test_alloc_miss;
    test_hit;
    test_noalloc_miss;
    test_flush_with_request;
    test_reset_mid_compare;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
